// File: rtl/rs_chien_search.sv
// Chien search for sigma(x) = 1 + s1 x + s2 x^2 + s3 x^3 over GF(2^8), poly 0x11D.
// Define CHIEN_EARLY_STOP_EN to end the sweep once err_cnt reaches the polynomial degree.
module rs_chien_search #(
    parameter int N = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] s1,
    input  logic [7:0] s2,
    input  logic [7:0] s3,
    output logic       busy,
    output logic       loc_valid,
    output logic [7:0] loc,
    output logic [1:0] err_cnt,
    output logic       done,
    output logic       fail
);
    typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, FINISH = 2'd2} state_t;

    localparam logic [8:0] N_LIM = 9'(N);

    function automatic logic [7:0] mul_a1(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    endfunction

    function automatic logic [7:0] mul_a2(input logic [7:0] x);
        return mul_a1(mul_a1(x));
    endfunction

    function automatic logic [7:0] mul_a3(input logic [7:0] x);
        return mul_a1(mul_a2(x));
    endfunction

    state_t     state_r;
    logic [7:0] t1_r, t2_r, t3_r, idx_r;
    logic [1:0] deg_r;
    logic       busy_r, loc_valid_r, done_r, fail_r;
    logic [7:0] loc_r;
    logic [1:0] err_cnt_r;

    logic [1:0] deg_s;
    logic [7:0] eval_s;
    logic       root_s;
    logic [7:0] root_loc_s;

    // Degree of the incoming polynomial and evaluation of the current index.
    always_comb begin
        if (s3 != 8'h00) begin
            deg_s = 2'd3;
        end else if (s2 != 8'h00) begin
            deg_s = 2'd2;
        end else if (s1 != 8'h00) begin
            deg_s = 2'd1;
        end else begin
            deg_s = 2'd0;
        end
        eval_s     = 8'h01 ^ t1_r ^ t2_r ^ t3_r;
        root_s     = (state_r == SEARCH) && (eval_s == 8'h00);
        root_loc_s = (idx_r == 8'd0) ? 8'd0 : (8'd255 - idx_r);
    end

    // Search FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            t1_r        <= 8'h00;
            t2_r        <= 8'h00;
            t3_r        <= 8'h00;
            idx_r       <= 8'd0;
            deg_r       <= 2'd0;
            busy_r      <= 1'b0;
            loc_valid_r <= 1'b0;
            loc_r       <= 8'd0;
            err_cnt_r   <= 2'd0;
            done_r      <= 1'b0;
            fail_r      <= 1'b0;
        end else begin
            loc_valid_r <= 1'b0;
            done_r      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        t1_r      <= s1;
                        t2_r      <= s2;
                        t3_r      <= s3;
                        idx_r     <= 8'd0;
                        deg_r     <= deg_s;
                        err_cnt_r <= 2'd0;
                        fail_r    <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= (deg_s == 2'd0) ? FINISH : SEARCH;
                    end
                end
                SEARCH: begin
                    t1_r  <= mul_a1(t1_r);
                    t2_r  <= mul_a2(t2_r);
                    t3_r  <= mul_a3(t3_r);
                    idx_r <= idx_r + 8'd1;
                    if (root_s) begin
                        loc_valid_r <= 1'b1;
                        loc_r       <= root_loc_s;
                        // A fourth root cannot exist for a true degree-3 locator.
                        if (({1'b0, root_loc_s} >= N_LIM) || (err_cnt_r == 2'd3)) begin
                            fail_r <= 1'b1;
                        end
                        if (err_cnt_r != 2'd3) begin
                            err_cnt_r <= err_cnt_r + 2'd1;
                        end
                    end
                    if (idx_r == 8'd254) begin
                        state_r <= FINISH;
`ifdef CHIEN_EARLY_STOP_EN
                    end else if (root_s && (err_cnt_r != 2'd3) && ((err_cnt_r + 2'd1) == deg_r)) begin
                        state_r <= FINISH;
`endif
                    end else begin
                        state_r <= SEARCH;
                    end
                end
                FINISH: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    if (err_cnt_r != deg_r) begin
                        fail_r <= 1'b1;
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign loc_valid = loc_valid_r;
    assign loc       = loc_r;
    assign err_cnt   = err_cnt_r;
    assign done      = done_r;
    assign fail      = fail_r;
endmodule

// File: tb/tb_rs_chien_search.sv
// Bench for rs_chien_search: brute-force GF(2^8) polynomial evaluation as reference,
// driving an N=255 and an N=4 instance with identical stimulus.
module tb_rs_chien_search;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] s1 = 8'h00, s2 = 8'h00, s3 = 8'h00;

    logic       busy_a, lv_a, done_a, fail_a;
    logic [7:0] loc_a;
    logic [1:0] cnt_a;
    logic       busy_b, lv_b, done_b, fail_b;
    logic [7:0] loc_b;
    logic [1:0] cnt_b;

    int checks = 0;
    int errors = 0;

    // Reference expectations, indexed by sample cycle (cycle k = sampled at edge Pk).
    bit       exp_lv  [0:299];
    int       exp_loc [0:299];
    int       exp_done;
    int       exp_cnt;
    bit       exp_fail_a, exp_fail_b;

    always #5 clk = ~clk;

    rs_chien_search #(.N(255)) dut_a (
        .clk(clk), .rst(rst), .start(start), .s1(s1), .s2(s2), .s3(s3),
        .busy(busy_a), .loc_valid(lv_a), .loc(loc_a), .err_cnt(cnt_a),
        .done(done_a), .fail(fail_a)
    );

    rs_chien_search #(.N(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .s1(s1), .s2(s2), .s3(s3),
        .busy(busy_b), .loc_valid(lv_b), .loc(loc_b), .err_cnt(cnt_b),
        .done(done_b), .fail(fail_b)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] gpow(input int e);
        logic [7:0] r = 8'h01;
        for (int k = 0; k < e; k++) r = gmul(r, 8'h02);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Brute-force evaluation of sigma at every alpha^i.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int deg, cnt, l;
        bit fa, fb;
        logic [7:0] x, v;
        for (int k = 0; k < 300; k++) begin
            exp_lv[k]  = 1'b0;
            exp_loc[k] = 0;
        end
        deg = (c != 0) ? 3 : (b != 0) ? 2 : (a != 0) ? 1 : 0;
        cnt = 0; fa = 1'b0; fb = 1'b0;
        exp_done = (deg == 0) ? 2 : 257;
        if (deg != 0) begin
            for (int i = 0; i < 255; i++) begin
                x = gpow(i);
                v = 8'h01 ^ gmul(a, x) ^ gmul(b, gmul(x, x)) ^ gmul(c, gmul(x, gmul(x, x)));
                if (v == 8'h00) begin
                    l = (255 - i) % 255;
                    exp_lv[2 + i]  = 1'b1;
                    exp_loc[2 + i] = l;
                    if (l >= 4) fb = 1'b1;
                    if (cnt == 3) begin
                        fa = 1'b1; fb = 1'b1;
                    end else begin
                        cnt++;
`ifdef CHIEN_EARLY_STOP_EN
                        if (cnt == deg) begin
                            exp_done = 3 + i;
                            break;
                        end
`endif
                    end
                end
            end
        end
        if (cnt != deg) begin
            fa = 1'b1; fb = 1'b1;
        end
        exp_cnt = cnt; exp_fail_a = fa; exp_fail_b = fb;
    endtask

    // One request; optional ignored start at inj, optional stop before edge abort_at.
    task automatic run_case(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input int inj, input int abort_at);
        model(a, b, c);
        @(negedge clk);
        s1 = a; s2 = b; s3 = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= exp_done + 1; cyc++) begin
            if (abort_at != 0 && cyc == abort_at) break;
            chk("loc_valid_a", 32'(lv_a), 32'(exp_lv[cyc]));
            chk("loc_valid_b", 32'(lv_b), 32'(exp_lv[cyc]));
            if (exp_lv[cyc]) begin
                chk("loc_a", 32'(loc_a), 32'(exp_loc[cyc]));
                chk("loc_b", 32'(loc_b), 32'(exp_loc[cyc]));
            end
            chk("done", 32'(done_a), 32'(cyc == exp_done));
            chk("busy", 32'(busy_a), 32'(cyc < exp_done));
            if (cyc == exp_done) begin
                chk("err_cnt", 32'(cnt_a), 32'(exp_cnt));
                chk("fail_a", 32'(fail_a), 32'(exp_fail_a));
                chk("fail_b", 32'(fail_b), 32'(exp_fail_b));
                chk("done_b", 32'(done_b), 32'd1);
            end
            if (cyc == inj) begin
                s1 = 8'h03; s2 = 8'h02; s3 = 8'h00; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (abort_at == 0) begin
            chk("err_cnt_hold", 32'(cnt_a), 32'(exp_cnt));
            chk("fail_hold", 32'(fail_a), 32'(exp_fail_a));
        end
    endtask

    initial begin
        logic [7:0] x1, x2, x3;
        int l1, l2, l3, nr;
        bit saw_done;

        #12;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_lv", 32'(lv_a), 32'd0);
        chk("rst_loc", 32'(loc_a), 32'd0);
        chk("rst_cnt", 32'(cnt_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_fail", 32'(fail_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_case(8'h20, 8'h00, 8'h00, 0, 0);   // single error at loc 5
        run_case(8'h03, 8'h02, 8'h00, 0, 0);   // roots at loc 0 and 1
        run_case(8'h00, 8'h00, 8'h00, 0, 0);   // no errors
        run_case(8'h00, 8'h01, 8'h00, 0, 0);   // repeated root
        run_case(8'h20, 8'h00, 8'h00, 50, 0);  // start mid-search ignored

        // Reset in the middle of a search.
        run_case(8'h20, 8'h00, 8'h00, 0, 100);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_lv", 32'(lv_a), 32'd0);
        chk("midrst_cnt", 32'(cnt_a), 32'd0);
        chk("midrst_done", 32'(done_a), 32'd0);
        chk("midrst_fail", 32'(fail_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 260; k++) begin
            @(negedge clk);
            if (done_a || busy_a || lv_a) saw_done = 1'b1;
        end
        chk("midrst_quiet", 32'(saw_done), 32'd0);
        run_case(8'h20, 8'h00, 8'h00, 0, 0);

        // Random locators built from distinct error locations.
        for (int r = 0; r < 6; r++) begin
            nr = $urandom_range(1, 3);
            l1 = $urandom_range(0, 254);
            do l2 = $urandom_range(0, 254); while (l2 == l1);
            do l3 = $urandom_range(0, 254); while (l3 == l1 || l3 == l2);
            x1 = gpow(l1); x2 = gpow(l2); x3 = gpow(l3);
            if (nr == 1)
                run_case(x1, 8'h00, 8'h00, 0, 0);
            else if (nr == 2)
                run_case(x1 ^ x2, gmul(x1, x2), 8'h00, 0, 0);
            else
                run_case(x1 ^ x2 ^ x3, gmul(x1, x2) ^ gmul(x1, x3) ^ gmul(x2, x3),
                         gmul(x1, gmul(x2, x3)), 0, 0);
        end

        // Arbitrary coefficients, frequently undecodable.
        for (int r = 0; r < 3; r++) begin
            run_case(8'($urandom), 8'($urandom), 8'($urandom_range(0, 255)), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
